sd_cmd_engine: RTL and testbench

SD_CMD_ENGINE -- requirements
Module: sd_cmd_engine

---
 rtl/sd_cmd_engine_if.sv | 26 ++
 rtl/sd_cmd_engine.sv | 200 ++++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_engine_if.sv
// Signal bundle between the SD command engine, its command requester and the SPI byte transactor.
// The master modport is the engine side; the slave modport is the requester/transactor side.
interface sd_cmd_engine_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        xfer_start;
    logic [7:0]  xfer_tx;
    logic [7:0]  xfer_rx;
    logic        xfer_done;
    logic        cs_n;
    logic        resp_valid;
    logic [7:0]  resp_r1;
    logic        resp_timeout;

    modport master (
        input  cmd_valid, cmd_index, cmd_arg, xfer_rx, xfer_done,
        output cmd_ready, xfer_start, xfer_tx, cs_n, resp_valid, resp_r1, resp_timeout
    );

    modport slave (
        output cmd_valid, cmd_index, cmd_arg, xfer_rx, xfer_done,
        input  cmd_ready, xfer_start, xfer_tx, cs_n, resp_valid, resp_r1, resp_timeout
    );
endinterface

// File: rtl/sd_cmd_engine.sv
// SPI-mode SD command engine: sends a 6-byte command frame, polls for R1, then clocks one tail byte.
// Define SD_CMD_CRC7_EN to generate the real CRC7 in byte 5; otherwise byte 5 is the fixed 0x95.
module sd_cmd_engine #(
    parameter int unsigned NCR_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    sd_cmd_engine_if.master  bus
);
    localparam logic [7:0] POLL_LAST = 8'(NCR_MAX - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_POLL = 3'd2,
        S_TAIL = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  byte_q, byte_d;
    logic [7:0]  poll_q, poll_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic        busy_q, busy_d;
    logic        start_q, start_d;
    logic [7:0]  tx_q, tx_d;
    logic        cs_n_q, cs_n_d;
    logic        ready_q, ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [7:0]  r1_q, r1_d;
    logic        tmo_q, tmo_d;
    logic        done_s;
    logic [7:0]  crc_byte_s;

    function automatic logic [7:0] frame_byte(input logic [2:0] n, input logic [5:0] idx,
                                              input logic [31:0] arg, input logic [7:0] crc);
        case (n)
            3'd0:    frame_byte = {2'b01, idx};
            3'd1:    frame_byte = arg[31:24];
            3'd2:    frame_byte = arg[23:16];
            3'd3:    frame_byte = arg[15:8];
            3'd4:    frame_byte = arg[7:0];
            3'd5:    frame_byte = crc;
            default: frame_byte = 8'hFF;
        endcase
    endfunction

`ifdef SD_CMD_CRC7_EN
    function automatic logic [6:0] crc7_calc(input logic [39:0] bits);
        logic [6:0] crc;
        logic       fb;
        crc = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb  = bits[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return crc;
    endfunction

    // Latched command fields are stable for the whole SEND phase, so a parallel CRC is ready in time.
    assign crc_byte_s = {crc7_calc({2'b01, idx_q, arg_q}), 1'b1};
`else
    assign crc_byte_s = 8'h95;
`endif

    // Completion pulses that arrive with nothing outstanding are dropped here.
    assign done_s = bus.xfer_done & busy_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        poll_d       = poll_q;
        idx_d        = idx_q;
        arg_d        = arg_q;
        busy_d       = busy_q & ~bus.xfer_done;
        start_d      = 1'b0;
        tx_d         = tx_q;
        cs_n_d       = cs_n_q;
        ready_d      = ready_q;
        resp_valid_d = 1'b0;
        r1_d         = r1_q;
        tmo_d        = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && ready_q) begin
                    idx_d   = bus.cmd_index;
                    arg_d   = bus.cmd_arg;
                    cs_n_d  = 1'b0;
                    tmo_d   = 1'b0;
                    r1_d    = 8'hFF;
                    byte_d  = 3'd0;
                    ready_d = 1'b0;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    tx_d    = frame_byte(3'd0, bus.cmd_index, bus.cmd_arg, crc_byte_s);
                    state_d = S_SEND;
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_SEND: begin
                if (done_s) begin
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    if (byte_q == 3'd5) begin
                        poll_d  = 8'd0;
                        tx_d    = 8'hFF;
                        state_d = S_POLL;
                    end else begin
                        byte_d = byte_q + 3'd1;
                        tx_d   = frame_byte(byte_q + 3'd1, idx_q, arg_q, crc_byte_s);
                    end
                end else begin
                    byte_d = byte_q;
                end
            end
            S_POLL: begin
                if (done_s) begin
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    tx_d    = 8'hFF;
                    if (!bus.xfer_rx[7]) begin
                        r1_d    = bus.xfer_rx;
                        state_d = S_TAIL;
                    end else if (poll_q == POLL_LAST) begin
                        r1_d    = 8'hFF;
                        tmo_d   = 1'b1;
                        state_d = S_TAIL;
                    end else begin
                        poll_d = poll_q + 8'd1;
                    end
                end else begin
                    poll_d = poll_q;
                end
            end
            S_TAIL: begin
                if (done_s) begin
                    cs_n_d       = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    cs_n_d = 1'b0;
                end
            end
            S_DONE: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                cs_n_d  = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            byte_q       <= 3'd0;
            poll_q       <= 8'd0;
            idx_q        <= 6'd0;
            arg_q        <= 32'd0;
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
            tx_q         <= 8'hFF;
            cs_n_q       <= 1'b1;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            r1_q         <= 8'hFF;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            poll_q       <= poll_d;
            idx_q        <= idx_d;
            arg_q        <= arg_d;
            busy_q       <= busy_d;
            start_q      <= start_d;
            tx_q         <= tx_d;
            cs_n_q       <= cs_n_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            r1_q         <= r1_d;
            tmo_q        <= tmo_d;
        end
    end

    assign bus.cmd_ready    = ready_q;
    assign bus.xfer_start   = start_q;
    assign bus.xfer_tx      = tx_q;
    assign bus.cs_n         = cs_n_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_r1      = r1_q;
    assign bus.resp_timeout = tmo_q;
endmodule

// File: tb/tb_sd_cmd_engine.sv
// Randomized self-checking bench for sd_cmd_engine: a byte responder with random latency and a
// frame/poll reference model built from the command-protocol rules.
module tb_sd_cmd_engine;
    localparam int NCR_MAX    = 8;
    localparam int POLL_DEPTH = 300;

    logic clk;
    logic rst_n;
    logic rsp_done;
    logic stray_done;
    logic [7:0] rsp_rx;

    sd_cmd_engine_if bus ();

    sd_cmd_engine #(.NCR_MAX(NCR_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    assign bus.xfer_done = rsp_done | stray_done;
    assign bus.xfer_rx   = rsp_rx;

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;
    int rv_cnt   = 0;
    bit active   = 1'b0;
    logic [7:0] tx_log[$];
    logic [7:0] exp_q[$];
    logic [7:0] poll_rx[POLL_DEPTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    // Byte transactor model: random completion latency, checks xfer_tx stability meanwhile.
    initial begin
        logic [7:0] tx_now;
        int n_now;
        int dly;
        bit aborted;
        rsp_done = 1'b0;
        rsp_rx   = 8'h00;
        forever begin
            @(negedge clk);
            while (bus.xfer_start === 1'b1 && rst_n === 1'b1) begin
                tx_now = bus.xfer_tx;
                tx_log.push_back(tx_now);
                n_now = xfer_cnt;
                xfer_cnt++;
                dly = $urandom_range(40, 1);
                aborted = 1'b0;
                for (int c = 0; c < dly; c++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    check_val("tx_stable", bus.xfer_tx, tx_now);
                    check_val("start_one_cycle", bus.xfer_start, 1'b0);
                end
                if (!aborted) begin
                    rsp_rx = (n_now >= 6 && n_now < 6 + POLL_DEPTH) ? poll_rx[n_now - 6] : 8'($urandom);
                    rsp_done = 1'b1;
                    @(negedge clk);
                    rsp_done = 1'b0;
                    rsp_rx = 8'($urandom);
                end
            end
        end
    end

    // Completion pulse counter and continuous chip-select check during a command.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) rv_cnt++;
            if (active && bus.resp_valid !== 1'b1) check_val("cs_held_low", bus.cs_n, 1'b0);
        end
    end

    task automatic fill_poll(input int valid_pos, input logic [7:0] r1);
        for (int p = 0; p < POLL_DEPTH; p++) poll_rx[p] = 8'($urandom_range(255, 128));
        if (valid_pos >= 0 && valid_pos < POLL_DEPTH) poll_rx[valid_pos] = r1;
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit hold);
        int budget;
        int k;
        int npoll;
        bit found;
        logic [7:0] r1_exp;
        logic [46:0] rem;
        exp_q.delete();
        tx_log.delete();
        xfer_cnt = 0;
        rv_cnt = 0;
        exp_q.push_back({2'b01, idx});
        for (int i = 0; i < 4; i++) exp_q.push_back(8'((arg >> (8 * (3 - i))) & 32'hFF));
`ifdef SD_CMD_CRC7_EN
        rem = {2'b01, idx, arg, 7'd0};
        for (int b = 46; b >= 7; b--) if (rem[b]) rem = rem ^ (47'h89 << (b - 7));
        exp_q.push_back({rem[6:0], 1'b1});
`else
        rem = 47'd0;
        exp_q.push_back(8'h95 | {1'b0, rem[6:0]});
`endif
        found = 1'b0;
        k = 0;
        for (int p = 0; p < NCR_MAX; p++) begin
            if (!found && poll_rx[p] < 8'h80) begin
                found = 1'b1;
                k = p;
            end
        end
        npoll  = found ? k + 1 : NCR_MAX;
        r1_exp = found ? poll_rx[k] : 8'hFF;
        repeat (npoll + 1) exp_q.push_back(8'hFF);

        bus.cmd_index = idx;
        bus.cmd_arg   = arg;
        bus.cmd_valid = 1'b1;
        budget = 0;
        while (bus.cmd_ready !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check_val("accept_ready", bus.cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) bus.cmd_valid = 1'b0;
        active = 1'b1;
        @(negedge clk);
        check_val("first_start", bus.xfer_start, 1'b1);
        check_val("cs_low_after_accept", bus.cs_n, 1'b0);
        check_val("ready_low_busy", bus.cmd_ready, 1'b0);
        budget = 0;
        while (bus.resp_valid !== 1'b1 && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        active = 1'b0;
        check_val("resp_valid_seen", bus.resp_valid, 1'b1);
        check_val("cs_high_in_done", bus.cs_n, 1'b1);
        check_val("resp_r1", bus.resp_r1, r1_exp);
        check_val("resp_timeout", bus.resp_timeout, !found);
        check_val("tx_count", tx_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
            check_val($sformatf("tx_byte%0d", i), tx_log[i], exp_q[i]);
        @(negedge clk);
        check_val("ready_after_done", bus.cmd_ready, 1'b1);
        check_val("resp_valid_one_cycle", bus.resp_valid, 1'b0);
        check_val("one_resp_pulse", rv_cnt, 1);
        check_val("r1_held", bus.resp_r1, r1_exp);
    endtask

    initial begin
        int budget;
        rst_n         = 1'b0;
        stray_done    = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_index = 6'd0;
        bus.cmd_arg   = 32'd0;
        fill_poll(-1, 8'h00);
        #15;
        check_val("rst_cs_n", bus.cs_n, 1'b1);
        check_val("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check_val("rst_xfer_start", bus.xfer_start, 1'b0);
        check_val("rst_xfer_tx", bus.xfer_tx, 8'hFF);
        check_val("rst_resp_valid", bus.resp_valid, 1'b0);
        check_val("rst_resp_r1", bus.resp_r1, 8'hFF);
        check_val("rst_resp_timeout", bus.resp_timeout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Stray completion while idle must not start anything.
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        check_val("stray_no_start", bus.xfer_start, 1'b0);
        check_val("stray_ready", bus.cmd_ready, 1'b1);
        @(negedge clk);
        check_val("stray_cs_n", bus.cs_n, 1'b1);

        // CMD0: responder gives 0xFF then 0x01.
        fill_poll(1, 8'h01);
        run_cmd(6'd0, 32'h0000_0000, 1'b0);
        // CMD8 with arg 0x1AA, immediate R1.
        fill_poll(0, 8'h01);
        run_cmd(6'd8, 32'h0000_01AA, 1'b0);
`ifdef SD_CMD_CRC7_EN
        if (tx_log.size() > 5) check_val("cmd8_crc", tx_log[5], 8'h87);
`else
        if (tx_log.size() > 5) check_val("cmd8_fixed_crc", tx_log[5], 8'h95);
`endif
        // Timeout and the two poll-window boundaries.
        fill_poll(-1, 8'h00);
        run_cmd(6'd17, 32'h1234_5678, 1'b0);
        fill_poll(NCR_MAX - 1, 8'h05);
        run_cmd(6'd55, 32'hDEAD_BEEF, 1'b0);
        fill_poll(NCR_MAX, 8'h00);
        run_cmd(6'd41, 32'h4000_0000, 1'b0);

        // cmd_valid held through a command: second accepted on first ready cycle.
        fill_poll(2, 8'h00);
        run_cmd(6'd1, 32'hA5A5_0F0F, 1'b1);
        fill_poll(0, 8'h7F);
        run_cmd(6'd2, 32'h0102_0304, 1'b0);

        // Reset during SEND byte 3.
        fill_poll(1, 8'h01);
        tx_log.delete();
        xfer_cnt = 0;
        bus.cmd_index = 6'd24;
        bus.cmd_arg   = 32'hCAFE_F00D;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        budget = 0;
        while (xfer_cnt < 4 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        check_val("reached_byte3", xfer_cnt, 4);
        rv_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_cs_n", bus.cs_n, 1'b1);
        check_val("abort_xfer_start", bus.xfer_start, 1'b0);
        check_val("abort_ready", bus.cmd_ready, 1'b1);
        repeat (3) @(negedge clk);
        check_val("abort_no_resp", rv_cnt, 0);
        bus.cmd_index = 6'd0;
        bus.cmd_arg   = 32'd0;
        bus.cmd_valid = 1'b1;
        rst_n = 1'b1;
        check_val("ready_after_release", bus.cmd_ready, 1'b1);
        run_cmd(6'd0, 32'h0000_0000, 1'b0);

        // Randomized commands and responder behaviour.
        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(9, 0) < 7) fill_poll($urandom_range(NCR_MAX + 1, 0), 8'($urandom_range(127, 0)));
            else fill_poll(-1, 8'h00);
            run_cmd(6'($urandom), $urandom, 1'b0);
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no end of test, required completion before time limit");
        $fatal(1);
    end
endmodule
